// File: rtl/store_merge.sv
// -----------------------------------------------------------------------------
// store_merge
//
// Store-side data path for the single-issue MIPS core. Takes a sw/sh/sb
// request carrying a full 32-bit register value, narrows it to the addressed
// byte lanes and writes it into a word-wide synchronous data RAM that has no
// byte enables. Sub-word stores use read-modify-write; full-word stores are
// written directly.
//
// Ports:
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high
//   req_valid  in   1       store request present
//   req_ready  out  1       unit idle and able to accept
//   req_op     in   2       0 = sw, 1 = sh, 2 = sb, 3 = reserved
//   req_addr   in   32      byte address
//   req_data   in   32      rt value (low 16/8 bits used for sh/sb)
//   mem_addr   out  ADDR_W  word address latched at accept
//   mem_re     out  1       RAM read strobe (rdata valid next cycle)
//   mem_rdata  in   32      RAM read data
//   mem_we     out  1       RAM write strobe
//   mem_wdata  out  32      merged write word
//   done       out  1       pulse coincident with mem_we
//   err        out  1       pulse for a rejected request
//   fsm_state  out  3       current FSM state, for observation
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE and depends on state
// alone; the requester must hold req_op/addr/data stable until that edge.
// req_valid while req_ready = 0 is ignored.
// -----------------------------------------------------------------------------
module store_merge #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   output logic              done,
   output logic              err,
   output logic [2:0]        fsm_state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_MERGE = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   localparam logic [1:0] OP_SW = 2'd0;
   localparam logic [1:0] OP_SH = 2'd1;
   localparam logic [1:0] OP_SB = 2'd2;

   logic [2:0]        state;
   logic [1:0]        op_q;
   logic [1:0]        off_q;
   logic [31:0]       data_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wbuf;

   logic              accept;
   logic              bad_req;
   logic [31:0]       merged;

   assign accept = req_valid && (state == S_IDLE);

   // Reserved op, misaligned word, or halfword not on a 2-byte boundary.
   always_comb begin
      bad_req = 1'b0;
      case (req_op)
         OP_SW:   bad_req = (req_addr[1:0] != 2'b00);
         OP_SH:   bad_req = req_addr[0];
         OP_SB:   bad_req = 1'b0;
         default: bad_req = 1'b1;
      endcase
   end

   // Replace the addressed lanes of the read word; little-endian lane order.
   always_comb begin
      merged = mem_rdata;
      if (op_q == OP_SB) begin
         case (off_q)
            2'd0:    merged[7:0]   = data_q[7:0];
            2'd1:    merged[15:8]  = data_q[7:0];
            2'd2:    merged[23:16] = data_q[7:0];
            default: merged[31:24] = data_q[7:0];
         endcase
      end else begin
         if (off_q[1]) merged[31:16] = data_q[15:0];
         else          merged[15:0]  = data_q[15:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         op_q   <= OP_SW;
         off_q  <= 2'd0;
         data_q <= 32'd0;
         addr_q <= '0;
         wbuf   <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q   <= req_op;
                  off_q  <= req_addr[1:0];
                  data_q <= req_data;
                  // Upper address bits are dropped: word address wraps.
                  addr_q <= req_addr[ADDR_W+1:2];
                  if (bad_req) begin
                     state <= S_ERR;
                  end else if (req_op == OP_SW) begin
                     wbuf  <= req_data;
                     state <= S_WRITE;
                  end else begin
                     state <= S_READ;
                  end
               end
            end
            S_READ:  state <= S_MERGE;
            S_MERGE: begin
               wbuf  <= merged;
               state <= S_WRITE;
            end
            S_WRITE: state <= S_IDLE;
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // All outputs decode from registered state only.
   assign req_ready = (state == S_IDLE);
   assign mem_re    = (state == S_READ);
   assign mem_we    = (state == S_WRITE);
   assign done      = (state == S_WRITE);
   assign err       = (state == S_ERR);
   assign mem_addr  = addr_q;
   assign mem_wdata = wbuf;
   assign fsm_state = state;

endmodule

// File: doc/store_merge.md
# store_merge

Store-side data path unit for the single-issue MIPS core: it takes a `sw`/`sh`/`sb` request carrying a full 32-bit register value and narrows it to the addressed byte lanes. It then writes the result into a word-wide synchronous data RAM that has no byte enables. Sub-word stores are done as read-modify-write; full-word stores are written directly. The unit sits between the MEM-stage control and the data RAM, and performs the inverse of load-side sign/zero extension.

## Interface

Parameters:
- `ADDR_W`, default 12 — word-address width of the data RAM (4096 words).

Ports:
- `clk`  in  1  — single clock, all state updates on rising edge.
- `reset`  in  1  — asynchronous, active-high; forces IDLE and reset values immediately.
- `req_valid`  in  1  — store request present.
- `req_ready`  out  1  — unit can accept; request accepted on the edge where `req_valid & req_ready`.
- `req_op`  in  2  — 0 = `sw`, 1 = `sh`, 2 = `sb`, 3 = reserved.
- `req_addr`  in  32  — byte address.
- `req_data`  in  32  — register (rt) value; only the low 16/8 bits are used for `sh`/`sb`.
- `mem_addr`  out  ADDR_W  — word address, equal to `req_addr[ADDR_W+1:2]` latched at accept.
- `mem_re`  out  1  — RAM read strobe; `mem_rdata` is valid the cycle after.
- `mem_rdata`  in  32  — RAM read data.
- `mem_we`  out  1  — RAM write strobe, one cycle.
- `mem_wdata`  out  32  — merged write word.
- `done`  out  1  — one-cycle pulse, coincident with `mem_we`.
- `err`  out  1  — one-cycle pulse for a rejected request (misaligned or reserved op).

## Operation

The FSM has five states: IDLE, READ, MERGE, WRITE, ERR.

- **IDLE.** `req_ready` = 1; all other strobes are 0. On accept, the unit latches op, byte offset `addr[1:0]`, data and word address, then moves to:
  - ERR if op = 3, if `sw` has `addr[1:0]` ≠ 0, or if `sh` has `addr[0]` ≠ 0;
  - WRITE for `sw` (write buffer = `req_data`);
  - READ for `sh`/`sb`.
- **READ.** `mem_re` = 1. Next state is MERGE.
- **MERGE.** Write buffer = `mem_rdata` with the addressed lanes replaced:
  - `sb`, lane k = `addr[1:0]`: bits [8k+7:8k] ← `req_data[7:0]`;
  - `sh`, half h = `addr[1]`: bits [16h+15:16h] ← `req_data[15:0]`;
  - all other bits are kept from `mem_rdata`.
  - Next state is WRITE.
- **WRITE.** `mem_we` = 1, `done` = 1, `mem_wdata` = write buffer. Next state is IDLE.
- **ERR.** `err` = 1, no RAM access. Next state is IDLE.

Lane order is little-endian: byte 0 = bits [7:0].

All outputs decode from registered state, so no output depends combinationally on `req_*` or `mem_rdata`. `mem_addr` is held stable from accept until the unit returns to IDLE. `mem_wdata` equals the write buffer at all times; it is meaningful only while `mem_we` = 1.

## Timing

Accept occurs at edge T.
- `sw`: `mem_we`/`done` are high in cycle T+1.
- `sh`/`sb`: `mem_re` in T+1, MERGE in T+2, `mem_we`/`done` in T+3.
- Error: `err` in T+1.
- `req_ready` returns to 1 in the cycle after WRITE or ERR.
- Throughput: back-to-back `sw` = one store per 2 cycles; sub-word store = one per 4 cycles.

Reset values: state IDLE, `req_ready` = 1, `mem_re` = `mem_we` = `done` = `err` = 0, `mem_addr` = 0, `mem_wdata` = 0.

Boundary conditions:
- **Busy.** `req_valid` while `req_ready` = 0 is ignored. The requester must hold the request until it is accepted.
- **Reset mid-operation.** Asserting `reset` in READ, MERGE or WRITE aborts the store. No `mem_we` is issued after reset assertion, and no `done` is produced for the aborted request.
- **Address truncation.** Address bits above `ADDR_W+1` are ignored; the word address wraps modulo 2^ADDR_W.
- **`sw` and `mem_rdata`.** `mem_rdata` is never sampled for `sw`.

## Test plan

- **Full-word store.** `sw` with addr 0x0000_0010, data 0xDEAD_BEEF → `mem_we` at T+1 with `mem_addr` = 4 and `mem_wdata` = 0xDEAD_BEEF; `mem_re` is never asserted.
- **Byte store, all lanes.** RAM word 0x1122_3344; `sb` data 0xFFFF_FFAA to offsets 0..3 → `mem_wdata` = 0x1122_33AA, 0x1122_AA44, 0x11AA_3344, 0xAA22_3344, each at T+3.
- **Halfword store, upper half.** RAM word 0x1122_3344; `sh` at addr 0x6, data 0x0000_BEEF → `mem_re` at T+1, `mem_addr` = 1, `mem_wdata` = 0xBEEF_3344 at T+3.
- **Rejected requests.** `sh` at addr 0x3, `sw` at addr 0x2, and op = 3 → `err` pulse at T+1 for each, no `mem_re`/`mem_we`, `req_ready` = 1 at T+2.
- **Back-to-back and busy.** Keep `req_valid` high with an `sb` followed by an `sw` → second accept occurs at T+4 (not earlier), and `sw` writes at T+5.
- **Reset mid-operation.** Assert `reset` during MERGE of an `sb` → no `mem_we`/`done`; after release `req_ready` = 1 and a following `sw` completes normally.
